mult_seq: RTL and testbench
===========================

# mult_seq

Iterative 32-bit unsigned shift-and-add multiplier that drives the shared ALU as an initiator on the `alu_if` signal set, issuing `ALU_ADD` operations and consuming `port_o`. It sits beside the datapath as a multi-cycle execution unit. It returns the low 32 bits of `a*b` and holds the operand path to the ALU while busy.

## Interface
Parameters:
- `WIDTH`, 32, operand and product width; must equal the `word_t` width.

Ports:
- `CLK` in 1: rising-edge clock.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE or DONE.
- `a` in WIDTH: multiplicand, captured on accepted `start`.
- `b` in WIDTH: multiplier, captured on accepted `start`.
- `busy` out 1: high in RUN.
- `done` out 1: high for exactly the one DONE cycle.
- `product` out WIDTH: low word of the result, held until the next accepted `start`.
- `port_a` out WIDTH: ALU operand A, the `alu_if` signal.
- `port_b` out WIDTH: ALU operand B.
- `aluop` out 4: constant `ALU_ADD` from `cpu_types_pkg`.
- `port_o` in WIDTH: ALU result.

## Operation
- FSM states:
  - IDLE: no operation in progress.
  - RUN: iterating.
  - DONE: result valid; lasts one cycle, then returns to IDLE.
- IDLE/DONE with `start=1`:
  - `mcand<=a`, `mplier<=b`, `acc<=0`, `cnt<=0`.
  - Go to RUN.
  - In DONE, this start replaces the return to IDLE.
- RUN, every cycle:
  - Drive `port_a=acc`, `port_b=mcand`.
  - If `mplier[0]`, `acc<=port_o`; otherwise `acc` is unchanged.
  - `mcand<=mcand<<1`, `mplier<=mplier>>1`, `cnt<=cnt+1`.
- RUN exit: when `cnt==WIDTH-1`, the current cycle is the last update; then `product<=` final `acc` and go to DONE.
- Arithmetic is modulo 2^WIDTH. Carries out of the ALU and the `ov` flag are ignored.
- `start` during RUN is ignored: no capture, no restart.
- Outside RUN, `port_a=0` and `port_b=0`.
- `aluop` is always `ALU_ADD`.

## Timing
- Reset values:
  - state IDLE.
  - `busy=0`, `done=0`, `product=0`.
  - `port_a=0`, `port_b=0`.
  - internal registers 0.
- Reset asserted mid-RUN aborts immediately. `product` returns to 0 and no `done` is issued.
- Latency, with `start` accepted at edge 0:
  - RUN occupies cycles 1..WIDTH.
  - `done=1` in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - `product` is valid from that cycle on.
- Throughput: back-to-back starts taken in DONE give one result per WIDTH+1 cycles.
- `busy` and `done` are never high together.
- The ALU is combinational, so `port_o` is sampled in the same cycle as `port_a`/`port_b` are driven.

## Configuration
- `MULT_EARLY_EXIT_EN` defined:
  - In RUN, if the current `mplier==0`, go straight to DONE with `product<=acc` and perform no update that cycle.
  - Resulting timing: `b=0` gives `done` in cycle 2; `b=1` gives `done` in cycle 3; `b=2^31` gives `done` in cycle 33.
- `MULT_EARLY_EXIT_EN` undefined: RUN always lasts exactly WIDTH cycles, whatever the operands.
- Result values are identical either way.

## Structure
- `cpu_types_pkg` additions:
  - `mult_state_t` enum {IDLE, RUN, DONE}.
  - `MULT_CNT_W` = 5 (clog2 of 32).
- Operands use `word_t`; `aluop` uses the existing `ALU_ADD` encoding.
- No internal sub-module. One wrapper is natural: `mult_alu_top`, which instantiates `mult_seq` and the ALU and connects them through an `alu_if` instance.

## Test plan
- `a=3`, `b=5`, start at edge 0: `busy` for cycles 1..32, then `done` in cycle 33 with `product=15`, then IDLE.
- `a=b=0xFFFFFFFF`: `product=0x00000001`; `a=b=0x00010000`: `product=0x00000000` (wrap-around).
- Start in DONE with `a=7`, `b=6`: no idle gap, RUN resumes next cycle, `product=42` in cycle 33 of the second op. The previous `product` holds until that cycle.
- `start` pulses with new operands during RUN: ignored, original result is delivered on schedule.
- `RST` asserted in cycle 10 of a RUN: `busy`, `done`, `product` and `port_a`/`port_b` go to 0 immediately; no `done` follows.
- Early exit, `b=1`, `a=9`: with `MULT_EARLY_EXIT_EN`, `done` in cycle 3; without it, `done` in cycle 33. `product=9` in both builds.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type, ALU operation encoding and the
// state/counter definitions used by the sequential multiplier.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Iteration counter width: clog2 of the 32-bit operand width.
  localparam int MULT_CNT_W = 5;

endpackage

// File: rtl/alu_if.sv
// Signal set between an ALU initiator (operands + opcode) and the
// combinational ALU (result).
interface alu_if;

  cpu_types_pkg::word_t  port_a;
  cpu_types_pkg::word_t  port_b;
  cpu_types_pkg::aluop_t aluop;
  cpu_types_pkg::word_t  port_o;

  modport master (output port_a, output port_b, output aluop, input port_o);
  modport slave  (input port_a, input port_b, input aluop, output port_o);

endinterface

// File: rtl/mult_seq.sv
// Iterative shift-and-add multiplier that borrows the shared ALU for its adds.
// Optional build macro MULT_EARLY_EXIT_EN ends RUN once the multiplier is exhausted.
module mult_seq
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  product,
  alu_if.master             alu,
  output mult_state_t       dbg_state
);

  // Handshake: start is a request that is accepted only when the unit is in
  // IDLE or DONE; done is a one-cycle result strobe; busy marks RUN; start
  // seen during RUN is dropped entirely.

  localparam logic [MULT_CNT_W-1:0] LAST_CNT = MULT_CNT_W'(WIDTH - 1);

  mult_state_t            state_q,   state_d;
  logic [WIDTH-1:0]       mcand_q,   mcand_d;
  logic [WIDTH-1:0]       mplier_q,  mplier_d;
  logic [WIDTH-1:0]       acc_q,     acc_d;
  logic [WIDTH-1:0]       product_q, product_d;
  logic [MULT_CNT_W-1:0]  cnt_q,     cnt_d;
  logic [WIDTH-1:0]       acc_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    product_d  = product_q;
    cnt_d      = cnt_q;
    alu.port_a = '0;
    alu.port_b = '0;
    // The ALU is combinational, so its sum is usable in the cycle it is asked for.
    acc_next   = mplier_q[0] ? alu.port_o : acc_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        alu.port_a = acc_q;
        alu.port_b = mcand_q;
`ifdef MULT_EARLY_EXIT_EN
        if (mplier_q == '0) begin
          product_d = acc_q;
          state_d   = DONE;
        end else begin
`else
        begin
`endif
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + MULT_CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            product_d = acc_next;
            state_d   = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign alu.aluop = ALU_ADD;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed cases plus randomized operands
// against an arithmetic reference model; the bench plays the combinational ALU.
module tb_mult_seq;
  import cpu_types_pkg::*;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  product;
  mult_state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               lat_q[$];
  logic [WIDTH-1:0] held_prod;

  alu_if u_alu ();

  // Only ALU_ADD gives a sum; any other opcode yields a visibly wrong result.
  assign u_alu.port_o = (u_alu.aluop == ALU_ADD) ? u_alu.port_a + u_alu.port_b
                                                 : u_alu.port_a - u_alu.port_b;

  mult_seq #(.WIDTH(WIDTH)) dut (
    .CLK       (clk),
    .RST       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .alu       (u_alu.master),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: product is the low word of the true product; the done cycle
  // follows from how many multiplier bits must be consumed.
  function automatic logic [WIDTH-1:0] ref_product(input logic [WIDTH-1:0] av,
                                                   input logic [WIDTH-1:0] bv);
    logic [2*WIDTH-1:0] full;
    full = {{WIDTH{1'b0}}, av} * {{WIDTH{1'b0}}, bv};
    return full[WIDTH-1:0];
  endfunction

  function automatic int ref_latency(input logic [WIDTH-1:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    int h;
    if (bv == '0) return 2;
    h = 0;
    for (int i = 0; i < WIDTH; i++) if (bv[i]) h = i;
    if (h == WIDTH - 1) return WIDTH + 1;
    return h + 3;
`else
    return (bv == '0) ? WIDTH + 1 : WIDTH + 1;
`endif
  endfunction

  // Called at a negedge; the request is taken at the next posedge (edge 0).
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    exp_q.push_back(ref_product(av, bv));
    lat_q.push_back(ref_latency(bv));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Returns at the negedge inside the DONE cycle.
  task automatic wait_done(input string tag, input logic [WIDTH-1:0] av, input bit poke);
    logic [WIDTH-1:0] ep;
    int               el;
    int               lat;
    ep  = exp_q.pop_front();
    el  = lat_q.pop_front();
    lat = 0;
    for (int n = 1; n <= WIDTH + 8; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_prod_hold"}, product, held_prod);
      if (n == 1) begin
        check({tag, "_port_a_c1"}, u_alu.port_a, '0);
        check({tag, "_port_b_c1"}, u_alu.port_b, av);
        check({tag, "_aluop"}, u_alu.aluop, ALU_ADD);
      end
      if (poke && n == 5) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_latency"}, lat, el);
    check({tag, "_product"}, product, ep);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_state_done"}, dbg_state, DONE);
    held_prod = ep;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_state"}, dbg_state, IDLE);
    check({tag, "_idle_ports"}, {u_alu.port_a, u_alu.port_b}, '0);
    check({tag, "_idle_prod"}, product, held_prod);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int               done_cnt;

    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    held_prod = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_product", product, '0);
    check("rst_ports", {u_alu.port_a, u_alu.port_b}, '0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", dbg_state, IDLE);
    check("aluop_idle", u_alu.aluop, ALU_ADD);

    issue(32'd3, 32'd5);
    wait_done("mul3x5", 32'd3, 1'b0);
    idle_check("mul3x5");

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("all_ones", 32'hFFFF_FFFF, 1'b0);
    idle_check("all_ones");

    issue(32'h0001_0000, 32'h0001_0000);
    wait_done("wrap", 32'h0001_0000, 1'b0);

    // Start taken in DONE: no idle gap before the next RUN.
    issue(32'd7, 32'd6);
    wait_done("b2b_7x6", 32'd7, 1'b0);
    idle_check("b2b_7x6");

    issue(32'h1234_5678, 32'h8000_0003);
    wait_done("ignore_start", 32'h1234_5678, 1'b1);
    idle_check("ignore_start");

    issue(32'd9, 32'd1);
    wait_done("early_b1", 32'd9, 1'b0);
    idle_check("early_b1");

    issue(32'hDEAD_BEEF, 32'd0);
    wait_done("b_zero", 32'hDEAD_BEEF, 1'b0);
    idle_check("b_zero");

    issue(32'd5, 32'h8000_0000);
    wait_done("b_msb", 32'd5, 1'b0);
    idle_check("b_msb");

    // Reset in cycle 10 of a RUN aborts at once and suppresses done.
    issue(32'h0BAD_F00D, 32'h8765_4321);
    for (int n = 1; n <= 10; n++) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_product", product, '0);
    check("midrst_ports", {u_alu.port_a, u_alu.port_b}, '0);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    held_prod = '0;
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < WIDTH + 8; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_rst", done_cnt, 0);
    check("prod_after_rst", product, '0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = WIDTH'($urandom_range(0, 15));
        1:       rb = $urandom;
        2:       rb = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        default: rb = $urandom_range(0, 1) ? '1 : '0;
      endcase
      issue(ra, rb);
      wait_done($sformatf("rnd%0d", i), ra, 1'b0);
      if ($urandom_range(0, 1) == 0) idle_check($sformatf("rnd%0d", i));
    end
    idle_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
